rgmii_tx_ddr_gen: RTL and testbench

RGMII_TX_DDR_GEN -- requirements
Module: rgmii_tx_ddr_gen

---
 rtl/rgmii_tx_ddr_gen_pkg.sv | 8 +
 rtl/rgmii_tx_ddr_gen.sv | 66 ++++++
 tb/tb_rgmii_tx_ddr_gen.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/rgmii_tx_ddr_gen_pkg.sv
// rgmii_tx_ddr_gen_pkg: shared MAC speed encodings and default RGMII clock divisors
package rgmii_tx_ddr_gen_pkg;
  localparam logic [1:0] SPEED_10M = 2'b00;
  localparam logic [1:0] SPEED_100M = 2'b01;
  localparam logic [1:0] SPEED_1000M = 2'b10;
  localparam int DIV_100_DEF = 5;
  localparam int DIV_10_DEF = 50;
endpackage

// File: rtl/rgmii_tx_ddr_gen.sv
// rgmii_tx_ddr_gen: GMII to RGMII DDR-pair generator with 10/100/1000 clock division
module rgmii_tx_ddr_gen import rgmii_tx_ddr_gen_pkg::*; #(
  parameter int DIV_100 = DIV_100_DEF,
  parameter int DIV_10 = DIV_10_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] speed,
  input  logic [7:0] mac_gmii_txd,
  input  logic       mac_gmii_tx_en,
  input  logic       mac_gmii_tx_er,
  output logic       mac_gmii_tx_clk_en,
  output logic       tx_clk_d1,
  output logic       tx_clk_d2,
  output logic [3:0] txd_d1,
  output logic [3:0] txd_d2,
  output logic       tx_ctl_d1,
  output logic       tx_ctl_d2,
  output logic [1:0] speed_active
);
  localparam int CW = $clog2(DIV_10);
  localparam int W = CW + 2;
  logic [CW-1:0] cnt;
  logic [7:0] h_txd, n_txd;
  logic h_en, h_er, n_en, n_er, gig, last;
  logic [W-1:0] p, k0, k1;
  always_comb begin
    gig = speed_active == SPEED_1000M;
    p = speed_active == SPEED_10M ? W'(DIV_10) : speed_active == SPEED_100M ? W'(DIV_100) : W'(1);
    k0 = {1'b0, cnt, 1'b0};
    k1 = {1'b0, cnt, 1'b1};
    last = {2'b00, cnt} == p - W'(1);
    n_txd = cnt == '0 ? mac_gmii_txd : h_txd;
    n_en = cnt == '0 ? mac_gmii_tx_en : h_en;
    n_er = cnt == '0 ? mac_gmii_tx_er : h_er;
  end
  assign mac_gmii_tx_clk_en = last;
  // speed is only taken at the period boundary so tx_clk never emits a runt pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      speed_active <= SPEED_1000M;
      h_txd <= '0;
      h_en <= 1'b0;
      h_er <= 1'b0;
      tx_clk_d1 <= 1'b1;
      tx_clk_d2 <= 1'b0;
      txd_d1 <= '0;
      txd_d2 <= '0;
      tx_ctl_d1 <= 1'b0;
      tx_ctl_d2 <= 1'b0;
    end else begin
      cnt <= last ? '0 : cnt + 1'b1;
      if (last) speed_active <= speed[1] ? SPEED_1000M : speed;
      h_txd <= n_txd;
      h_en <= n_en;
      h_er <= n_er;
      tx_clk_d1 <= k0 < p;
      tx_clk_d2 <= k1 < p;
      txd_d1 <= n_txd[3:0];
      txd_d2 <= gig ? n_txd[7:4] : n_txd[3:0];
      tx_ctl_d1 <= k0 < p ? n_en : n_en ^ n_er;
      tx_ctl_d2 <= k1 < p ? n_en : n_en ^ n_er;
    end
  end
endmodule

// File: tb/tb_rgmii_tx_ddr_gen.sv
// tb_rgmii_tx_ddr_gen: scoreboard bench with a half-slot reference model plus directed hand checks
module tb_rgmii_tx_ddr_gen;
  typedef struct packed {
    logic [1:0] tc;
    logic [7:0] txd;
    logic [1:0] ctl;
    logic       ce;
    logic [1:0] sa;
  } exp_t;
  logic clk = 1'b0;
  logic rst, en, er, ce, tc1, tc2, c1, c2;
  logic [1:0] speed, sa;
  logic [7:0] txd;
  logic [3:0] d1, d2;
  exp_t q[$];
  exp_t m_e;
  int vecs = 0, errs = 0;
  int m_cnt;
  logic [1:0] m_sa;
  logic [7:0] m_txd;
  logic m_en, m_er;
  logic [1:0] pat [5] = '{2'b11, 2'b11, 2'b10, 2'b00, 2'b00};
  int n, run, nruns, bad, ones, tco;
  int runs [4];
  logic [1:0] rs;

  rgmii_tx_ddr_gen #(.DIV_100(5), .DIV_10(50)) dut (
    .clk(clk), .rst(rst), .speed(speed), .mac_gmii_txd(txd),
    .mac_gmii_tx_en(en), .mac_gmii_tx_er(er), .mac_gmii_tx_clk_en(ce),
    .tx_clk_d1(tc1), .tx_clk_d2(tc2), .txd_d1(d1), .txd_d2(d2),
    .tx_ctl_d1(c1), .tx_ctl_d2(c2), .speed_active(sa)
  );

  always #5 clk = ~clk;

  function automatic int per(input logic [1:0] s);
    return s[1] ? 1 : s[0] ? 5 : 50;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
    end
  endtask

  // reference model: outputs the DUT should show after the coming edge
  task automatic model(output exp_t e);
    int p, k;
    if (rst) begin
      m_cnt = 0; m_sa = 2'b10; m_txd = '0; m_en = 1'b0; m_er = 1'b0;
      e = '{tc: 2'b10, txd: 8'h00, ctl: 2'b00, ce: 1'b1, sa: 2'b10};
    end else begin
      p = per(m_sa);
      if (m_cnt == 0) begin m_txd = txd; m_en = en; m_er = er; end
      for (int ph = 0; ph < 2; ph++) begin
        k = 2 * m_cnt + ph;
        e.tc[1 - ph] = k < p;
        e.ctl[1 - ph] = k < p ? m_en : m_en ^ m_er;
      end
      e.txd = p == 1 ? m_txd : {m_txd[3:0], m_txd[3:0]};
      m_cnt = m_cnt == p - 1 ? 0 : m_cnt + 1;
      if (m_cnt == 0) m_sa = speed[1] ? 2'b10 : speed;
      e.ce = m_cnt == per(m_sa) - 1;
      e.sa = m_sa;
    end
  endtask

  task automatic step(input logic r, input logic [1:0] s, input logic [7:0] d, input logic e_, input logic x);
    exp_t ex;
    rst = r; speed = s; txd = d; en = e_; er = x;
    model(ex);
    @(posedge clk);
    q.push_back(ex);
    @(negedge clk);
  endtask

  always @(negedge clk) if (q.size() > 0) begin
    m_e = q.pop_front();
    chk("sb_tx_clk", 8'({tc1, tc2}), 8'(m_e.tc));
    chk("sb_txd", {d2, d1}, m_e.txd);
    chk("sb_tx_ctl", 8'({c1, c2}), 8'(m_e.ctl));
    chk("sb_clk_en", 8'(ce), 8'(m_e.ce));
    chk("sb_speed_active", 8'(sa), 8'(m_e.sa));
  end

  initial begin
    step(1, 2'b10, 8'h00, 0, 0);
    step(1, 2'b10, 8'h00, 0, 0);
    chk("rst_tx_clk", 8'({tc1, tc2}), 8'h02);
    chk("rst_clk_en", 8'(ce), 8'h01);
    chk("rst_speed", 8'(sa), 8'h02);
    step(0, 2'b10, 8'hA5, 1, 0);
    chk("gig_txd", {d2, d1}, 8'hA5);
    chk("gig_ctl", 8'({c1, c2}), 8'h03);
    chk("gig_tx_clk", 8'({tc1, tc2}), 8'h02);
    step(0, 2'b10, 8'h5A, 1, 1);
    chk("gig_ctl_er", 8'({c1, c2}), 8'h02);
    chk("gig_txd2", {d2, d1}, 8'h5A);
    step(0, 2'b01, 8'h00, 0, 0);
    chk("to_100m", 8'(sa), 8'h01);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 2'b01, 8'(i), 1, 0);
      chk("100m_tx_clk", 8'({tc1, tc2}), 8'(pat[i % 5]));
      n += int'(ce);
    end
    chk("100m_clk_en_count", 8'(n), 8'd2);
    run = 0; nruns = 0;
    for (int i = 0; i < 55; i++) begin
      step(0, i == 0 ? 2'b01 : 2'b00, 8'h00, 0, 0);
      if (i == 3) chk("switch_hold", 8'(sa), 8'h01);
      if (i == 4) chk("switch_load", 8'(sa), 8'h00);
      rs = {tc1, tc2};
      for (int b = 1; b >= 0; b--) begin
        if (rs[b]) run++;
        else if (run > 0) begin
          if (nruns < 4) runs[nruns] = run;
          nruns++;
          run = 0;
        end
      end
    end
    chk("runt_nruns", 8'(nruns), 8'd2);
    chk("runt_first", 8'(runs[0]), 8'd5);
    chk("runt_second", 8'(runs[1]), 8'd50);
    bad = 0; ones = 0; tco = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 0) step(0, 2'b00, 8'h3C, 1, 1);
      else step(0, 2'b00, 8'(i), 0, 0);
      if ({d2, d1} !== 8'hCC) bad++;
      ones += int'(c1) + int'(c2);
      tco += int'(tc1) + int'(tc2);
    end
    chk("10m_txd_held", 8'(bad), 8'd0);
    chk("10m_ctl_ones", 8'(ones), 8'd50);
    chk("10m_tx_clk_ones", 8'(tco), 8'd50);
    for (int i = 0; i < 30; i++) step(0, 2'b00, 8'($urandom), 1'($urandom), 1'($urandom));
    step(1, 2'b00, 8'hFF, 1, 1);
    chk("midrst_tx_clk", 8'({tc1, tc2}), 8'h02);
    chk("midrst_txd", {d2, d1}, 8'h00);
    chk("midrst_ctl", 8'({c1, c2}), 8'h00);
    chk("midrst_clk_en", 8'(ce), 8'h01);
    chk("midrst_speed", 8'(sa), 8'h02);
    step(0, 2'b01, 8'h00, 0, 0);
    chk("post_rst_load", 8'(sa), 8'h01);
    step(0, 2'b00, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 2'b01, 8'h00, 0, 0);
    chk("glitch_ignored", 8'(sa), 8'h01);
    speed = 2'b01;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) speed = 2'($urandom_range(0, 3));
      step($urandom_range(0, 149) == 0, speed, 8'($urandom), 1'($urandom), 1'($urandom));
    end
    @(negedge clk);
    chk("queue_drained", 8'(q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
